// File: rtl/gray_img_server_if.sv
// ============================================================================
// Module      : gray_img_server_if
// Description : Bundles the host load stream and the LBP gray-read signals
//               for gray_img_server. The master modport is used by the host
//               and the LBP core; the slave modport is used by the server.
//               Optional macro GRAY_STAT_EN adds the rd_cnt statistic signal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_img_server_if #(
  parameter int DW = 8,
  parameter int AW = 14
);
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          finish;
`ifdef GRAY_STAT_EN
  logic [AW:0]   rd_cnt;
`endif

  modport master (
    output ld_valid, ld_data, gray_req, gray_addr, finish,
    input  ld_ready, gray_ready, gray_data
`ifdef GRAY_STAT_EN
    , input rd_cnt
`endif
  );

  modport slave (
    input  ld_valid, ld_data, gray_req, gray_addr, finish,
    output ld_ready, gray_ready, gray_data
`ifdef GRAY_STAT_EN
    , output rd_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/gray_img_server.sv
// ============================================================================
// Module      : gray_img_server
// Description : Loads a 128x128 8-bit image from a host byte stream, then
//               serves zero-latency LBP reads (sampled on the falling clock
//               edge) until the LBP core raises finish. A byte arriving after
//               finish starts the next image at address 0.
//               Optional macro GRAY_STAT_EN adds the saturating rd_cnt
//               read counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_img_server #(
  parameter int DW    = 8,
  parameter int AW    = 14,
  parameter int DEPTH = 16384
) (
  input  wire logic       clk,
  input  wire logic       reset,   // asynchronous, active low
  gray_img_server_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_wr_addr;
  logic          w_ld_acc;
  logic          w_rd_en;
  logic [DW-1:0] r_rd_q;
  logic [DW-1:0] r_mem [DEPTH];

  // A load byte is accepted in every state except SERVE.
  assign w_ld_acc = bus.ld_valid && (r_state != ST_SERVE);
  assign w_rd_en  = (r_state == ST_SERVE) && bus.gray_req;

  // Next-state, write pointer and write address decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_wr_addr    = r_wr_ptr;
    case (r_state)
      ST_LOAD: begin
        if (w_ld_acc) begin
          // Pointer wraps to 0 after the last pixel.
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          if (r_wr_ptr == AW'(DEPTH - 1)) begin
            w_state_nxt = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (bus.finish) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // The first byte of the next image lands at address 0 right away.
        w_wr_addr = '0;
        if (w_ld_acc) begin
          w_wr_ptr_nxt = AW'(1);
          w_state_nxt  = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt  = ST_LOAD;
        w_wr_ptr_nxt = '0;
      end
    endcase
  end

  // State and write pointer registers; reset abandons any partial image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_LOAD;
      r_wr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
    end
  end

  // Image storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      r_mem[w_wr_addr] <= bus.ld_data;
    end
  end

  // Falling-edge read so data is ready for the LBP at the next rising edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_q <= '0;
    end else if (w_rd_en) begin
      r_rd_q <= r_mem[bus.gray_addr];
    end
  end

  assign bus.ld_ready   = (r_state != ST_SERVE);
  assign bus.gray_ready = (r_state == ST_SERVE);
  assign bus.gray_data  = (r_state == ST_SERVE) ? r_rd_q : '0;

`ifdef GRAY_STAT_EN
  logic [AW:0] r_rd_cnt;

  // Counts falling-edge reads, saturating at 2^AW. The count is held through
  // DONE and zeroed once a new image starts loading.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_cnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_rd_cnt <= '0;
    end else if (w_rd_en && (r_rd_cnt != {1'b1, {AW{1'b0}}})) begin
      r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  assign bus.rd_cnt = r_rd_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_img_server.sv
// ============================================================================
// Module      : tb_gray_img_server
// Description : Self-checking bench for gray_img_server. Read requests push
//               their expected pixel into a queue; a monitor pops and compares
//               just before the rising edge on which the LBP would capture.
//               Status outputs are checked directly by the stimulus process.
//               rd_cnt checks are present when GRAY_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_img_server;

  localparam int DEPTH = 16384;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  gray_img_server_if #(.DW(8), .AW(14)) bus();

  gray_img_server #(.DW(8), .AW(14), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a served request is visible 1 time unit before the capture edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (bus.gray_req && bus.gray_ready && !bus.finish) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL read_unexpected: got 0x%0h with no expected entry at %0t",
                   bus.gray_data, $time);
        end else begin
          check("read_data", 32'(bus.gray_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic load_byte(input logic [7:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic read_px(input logic [13:0] a, input logic [7:0] e);
    bus.gray_req  = 1'b1;
    bus.gray_addr = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'hEE;
    bus.gray_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int j);
    return 8'((j * 7 + 3) % 256);
  endfunction

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_data   = 8'h00;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.finish    = 1'b0;

    // Reset values
    #12;
    check("rst_ld_ready",   32'(bus.ld_ready),   32'd1);
    check("rst_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("rst_gray_data",  32'(bus.gray_data),  32'd0);
`ifdef GRAY_STAT_EN
    check("rst_rd_cnt", 32'(bus.rd_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Partial load, then asynchronous reset in mid-cycle
    for (int i = 0; i < 100; i++) load_byte(8'(i));
    bus.ld_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_ld_ready",   32'(bus.ld_ready),   32'd1);
    check("arst_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("arst_gray_data",  32'(bus.gray_data),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Full load from address 0 with valid held high
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        check("load_last_gray_ready", 32'(bus.gray_ready), 32'd0);
        check("load_last_ld_ready",   32'(bus.ld_ready),   32'd1);
      end
      load_byte(8'(i));
    end
    bus.ld_valid = 1'b0;
    check("serve_gray_ready", 32'(bus.gray_ready), 32'd1);
    check("serve_ld_ready",   32'(bus.ld_ready),   32'd0);

    // Back-to-back reads, then hold with gray_req low
    read_px(14'd99,    8'h63);
    read_px(14'h0081,  8'h81);
    read_px(14'h3FFF,  8'hFF);
    idle(1);
    check("rd_hold", 32'(bus.gray_data), 32'hFF);

    // Load beats are ignored while serving
    load_byte(8'h55);
    bus.ld_valid = 1'b0;
    check("serve_ignore_ld_ready", 32'(bus.ld_ready), 32'd0);
    read_px(14'd0, 8'h00);

    // finish with a same-cycle request: request is dropped
    bus.finish    = 1'b1;
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd5;
    @(posedge clk);
    #1;
    bus.finish   = 1'b0;
    bus.gray_req = 1'b0;
    check("done_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("done_gray_data",  32'(bus.gray_data),  32'd0);
    check("done_ld_ready",   32'(bus.ld_ready),   32'd1);
`ifdef GRAY_STAT_EN
    check("done_rd_cnt", 32'(bus.rd_cnt), 32'd5);
`endif
    // Requests in DONE are ignored
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h3FFF;
    idle(1);
    check("done_req_gray_data", 32'(bus.gray_data), 32'd0);

    // Restart with 0xAA, then a reload with valid toggling 1,0,0 at first
    load_byte(8'hAA);
    bus.ld_valid = 1'b0;
    check("restart_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("restart_ld_ready",   32'(bus.ld_ready),   32'd1);
    for (int j = 1; j < DEPTH; j++) begin
      if (j == DEPTH - 1) check("reload_last_gray_ready", 32'(bus.gray_ready), 32'd0);
      load_byte(pat(j));
      if (j <= 60) idle(2);
    end
    bus.ld_valid = 1'b0;
    check("reload_gray_ready", 32'(bus.gray_ready), 32'd1);
`ifdef GRAY_STAT_EN
    check("reload_rd_cnt", 32'(bus.rd_cnt), 32'd0);
`endif
    read_px(14'd0,    8'hAA);
    read_px(14'd5,    8'h26);
    read_px(14'h3FFF, 8'hFC);
    read_px(14'd1,    8'h0A);
    idle(1);
`ifdef GRAY_STAT_EN
    check("serve2_rd_cnt", 32'(bus.rd_cnt), 32'd4);
`endif

    // Asynchronous reset while serving
    #2;
    reset = 1'b0;
    #1;
    check("arst_serve_gray_ready", 32'(bus.gray_ready), 32'd0);
    check("arst_serve_gray_data",  32'(bus.gray_data),  32'd0);
    check("arst_serve_ld_ready",   32'(bus.ld_ready),   32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_img_server.md
# gray_img_server

Responder for the gray-image read interface used by the LBP engine. Accepts a 128x128 8-bit grayscale image as a byte stream from the host, holds it in on-chip storage, then serves the `gray_req`/`gray_addr` → `gray_data` requests issued by the LBP core until that core raises `finish`. It sits between the host loader and the LBP core and is the synthesizable counterpart of the bench's gray memory model.

## Interface

- `DW`, 8, pixel width
- `AW`, 14, address width
- `DEPTH`, 16384, pixels per image (128x128)

- `clk`  in  1  system clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `ld_valid`  in  1  host byte valid
- `ld_data`  in  DW  host pixel byte, raster order from address 0
- `ld_ready`  out  1  server accepts a load byte this cycle
- `gray_ready`  out  1  image fully loaded; requests are served
- `gray_req`  in  1  LBP read request
- `gray_addr`  in  AW  LBP read address
- `gray_data`  out  DW  read data
- `finish`  in  1  LBP done; ends the serve phase
- `rd_cnt`  out  AW+1  accepted-read counter (only with `GRAY_STAT_EN`)

## Operation

- States: LOAD, SERVE, DONE. Reset → LOAD, `wr_ptr`=0.
- LOAD: `ld_ready`=1. A beat with `ld_valid&&ld_ready` at posedge writes `mem[wr_ptr]`=`ld_data` and increments `wr_ptr`. When the beat at `wr_ptr`==DEPTH-1 is written, go to SERVE. `ld_valid` gaps are allowed; only accepted beats count.
- SERVE: `ld_ready`=0 and `ld_valid` is ignored. `gray_ready`=1 (registered state decode).
- Read path: on the falling edge of `clk`, if state==SERVE and `gray_req`=1, then `rd_q` ← `mem[gray_addr]`. `gray_data` = (state==SERVE) ? `rd_q` : 0. `rd_q` holds its value while `gray_req`=0.
- `finish`=1 sampled at posedge in SERVE → DONE.
- DONE: `gray_ready`=0, `gray_data`=0, `ld_ready`=1. The first accepted `ld_valid` beat is written to address 0, sets `wr_ptr`=1, and moves to LOAD. That beat is not lost.
- `gray_req` outside SERVE is ignored. `finish` outside SERVE is ignored.
- Memory contents are not cleared by reset. `rd_q` resets to 0.
- Reset mid-LOAD discards the partial image: `wr_ptr`=0, and reload restarts from address 0.

## Timing

- Reset values: `ld_ready`=1, `gray_ready`=0, `gray_data`=0, `rd_cnt`=0.
- Load: 1 byte per cycle maximum. The 16384th accept at posedge N gives `gray_ready`=1 and `ld_ready`=0 from posedge N.
- Read: zero rising-edge latency, matching the LBP protocol.
  - The LBP drives `gray_req`/`gray_addr` after posedge k.
  - The server samples them at the following negedge.
  - `gray_data` is stable for LBP capture at posedge k+1.
  - Back-to-back requests give one pixel per cycle.
- `finish` at posedge M: from posedge M, `gray_ready`=0 and `gray_data`=0. A request in the same cycle as `finish` is dropped.

## Configuration

- `GRAY_STAT_EN` defined:
  - Port `rd_cnt` exists.
  - It increments on every negedge read performed in SERVE.
  - It saturates at 2^AW.
  - It clears on the DONE→LOAD transition and on reset.
- `GRAY_STAT_EN` undefined: the `rd_cnt` port and its counter are absent. All other behaviour is identical.

## Test plan

- Reset asserted mid-cycle, asynchronously → immediately `ld_ready`=1, `gray_ready`=0, `gray_data`=0x00.
- Load 16384 bytes with `ld_data`=i%256, `ld_valid` held high → `gray_ready` rises at the posedge of the 16384th accept; `ld_ready`=0 from the same edge.
- In SERVE, `gray_req`=1 with `gray_addr`=0x0081, then 0x3FFF, on consecutive cycles → `gray_data`=0x81, then 0xFF, at the next two posedges.
- Load with `ld_valid` toggling 1,0,0,1… → the image matches the accepted beats only; a read of address 5 returns the 6th accepted byte.
- `finish`=1 in SERVE → next posedge `gray_ready`=0 and `gray_data`=0. Then `ld_valid` with 0xAA → LOAD, and after a full reload a read of address 0 returns 0xAA. With `GRAY_STAT_EN`, `rd_cnt` reads 0 after the restart.
- Reset pulsed after 100 load beats → `wr_ptr` restarts. A full 16384-byte reload of i%256 followed by a read of address 99 returns 0x63.
